reg_dump_reader: RTL and testbench

//  Debug/readback engine for the CPU register file: on request, walks every

---
 rtl/reg_dump_reader.sv | 118 +++++++++++
 tb/tb_reg_dump_reader.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Debug readback engine. On start it walks register indices FIRST..NUM_REGS-1
//   through one combinational register-file read port. Each word is streamed
//   out over a valid/ready handshake, and an XOR checksum of every streamed
//   word is kept.
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start, abort         begin a dump (IDLE only) / cancel a dump in progress
//   rd_addr, rd_data     register-file read port (data is combinational)
//   out_valid/ready      stream handshake; out_data/out_index carry the word
//   busy, done           dump in progress / one-cycle normal completion pulse
//   checksum             XOR of streamed words; stable from done to next start
module reg_dump_reader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int SKIP_X0    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_index,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] checksum
);

    localparam logic [ADDR_WIDTH-1:0] FIRST = (SKIP_X0 != 0) ? ADDR_WIDTH'(1) : '0;
    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, READ, HOLD, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  accept;

    // abort outranks the handshake: a word offered while aborting is dropped
    assign accept  = out_valid & out_ready & ~abort;
    // idx is itself a register, so the read address is registered
    assign rd_addr = idx;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !abort) state_nxt = READ;
            end
            READ: begin
                busy      = 1'b1;
                state_nxt = abort ? IDLE : HOLD;
            end
            HOLD: begin
                busy = 1'b1;
                if (abort)       state_nxt = IDLE;
                else if (accept) state_nxt = (idx == LAST) ? DONE : READ;
            end
            DONE: begin
                busy      = 1'b1;
                // an abort landing on the final cycle suppresses the pulse
                done      = ~abort;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            checksum  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx      <= FIRST;
                        checksum <= '0;
                    end
                end
                READ: begin
                    // on abort the partial checksum is left untouched
                    if (!abort) begin
                        out_data  <= rd_data;
                        out_index <= idx;
                        checksum  <= checksum ^ rd_data;
                        out_valid <= 1'b1;
                    end
                end
                HOLD: begin
                    if (abort) begin
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        out_valid <= 1'b0;
                        // idx saturates at LAST; DONE follows instead of wrapping
                        if (idx != LAST) idx <= idx + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: default instance (skip x0, 32 regs) driven from a
// scenario table plus hand sequences, and a small instance (no skip, 4 regs).
module tb_reg_dump_reader;
    localparam int AW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] regs [32];

    // main instance
    logic          rst_n, start, abort, out_ready;
    logic [AW-1:0] rd_addr, out_index;
    logic [DW-1:0] rd_data, out_data, checksum;
    logic          out_valid, busy, done;
    assign rd_data = regs[rd_addr];

    reg_dump_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_index(out_index),
        .busy(busy), .done(done), .checksum(checksum)
    );

    // small instance: indices 0..3
    logic          rst_n2, start2, abort2, ready2;
    logic [AW-1:0] rd_addr2, out_index2;
    logic [DW-1:0] rd_data2, out_data2, checksum2;
    logic          out_valid2, busy2, done2;
    assign rd_data2 = regs[rd_addr2];

    reg_dump_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(4), .SKIP_X0(0)) dut4 (
        .clk(clk), .rst_n(rst_n2), .start(start2), .abort(abort2),
        .rd_addr(rd_addr2), .rd_data(rd_data2),
        .out_valid(out_valid2), .out_ready(ready2),
        .out_data(out_data2), .out_index(out_index2),
        .busy(busy2), .done(done2), .checksum(checksum2)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // scoreboard for the main instance: accepted words, done pulses, and
    // stability of an offered word until it is taken
    logic [AW-1:0] got_idx [$];
    logic [DW-1:0] got_dat [$];
    int            done_cnt = 0;
    logic [DW-1:0] exp_cs   = '0;
    bit            cs_chk_en = 1'b0;

    initial begin
        bit            pend;
        logic [DW-1:0] pdat;
        logic [AW-1:0] pidx;
        pend = 1'b0;
        pdat = '0;
        pidx = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (pend && out_valid) begin
                    chk("hold_data", 64'(out_data), 64'(pdat));
                    chk("hold_index", 64'(out_index), 64'(pidx));
                end
                if (out_valid && out_ready && !abort) begin
                    got_idx.push_back(out_index);
                    got_dat.push_back(out_data);
                end
                if (done) begin
                    done_cnt++;
                    if (cs_chk_en) chk("done_checksum", 64'(checksum), 64'(exp_cs));
                end
                pend = out_valid && !(out_ready && !abort);
                pdat = out_data;
                pidx = out_index;
            end else begin
                pend = 1'b0;
            end
        end
    end

    // scoreboard for the small instance
    logic [AW-1:0] got2_idx [$];
    logic [DW-1:0] got2_dat [$];
    int            done2_cnt = 0;
    int            acc3_cyc  = -10;
    int            done2_cyc = -20;

    initial forever begin
        @(negedge clk);
        if (rst_n2) begin
            if (out_valid2 && ready2 && !abort2) begin
                got2_idx.push_back(out_index2);
                got2_dat.push_back(out_data2);
                if (out_index2 == AW'(3)) acc3_cyc = cyc;
            end
            if (done2) begin
                done2_cnt++;
                done2_cyc = cyc;
            end
        end
    end

    typedef struct {
        int pct;        // chance (%) that out_ready is high in a cycle
        int bp_idx;     // index held off for 5 cycles (-1: none)
        int abort_idx;  // abort while this index is offered (-1: none)
        int mid_idx;    // pulse start while this index is offered (-1: none)
        int pat;        // 0: reg[i]=i*0x11, 1: random contents
        int exp_words;  // words the sink should receive
    } vec_t;

    task automatic fill_regs(input int pat);
        for (int i = 0; i < 32; i++)
            regs[i] = (pat == 0) ? 32'(i * 17) : $urandom();
    endtask

    task automatic dump(input vec_t v);
        logic [DW-1:0] cs, part;
        int  bp_cnt, n, lim;
        bit  fin, mid_sent;
        fill_regs(v.pat);
        cs   = '0;
        part = '0;
        for (int i = 1; i < 32; i++) cs ^= regs[i];
        for (int i = 1; i <= v.abort_idx; i++) part ^= regs[i];
        exp_cs    = cs;
        cs_chk_en = 1'b1;
        got_idx.delete();
        got_dat.delete();
        done_cnt  = 0;
        bp_cnt    = 0;
        fin       = 1'b0;
        mid_sent  = 1'b0;

        out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_busy", 64'(busy), 64'(1));
        chk("lat_valid_low", 64'(out_valid), 64'(0));
        chk("lat_addr", 64'(rd_addr), 64'(1));
        tick();
        chk("lat_valid_high", 64'(out_valid), 64'(1));
        chk("first_index", 64'(out_index), 64'(1));

        n = 0;
        while (n < 2000 && done_cnt == 0 && !fin) begin
            start = 1'b0;
            abort = 1'b0;
            out_ready = (int'($urandom_range(99)) < v.pct);
            if (out_valid && int'(out_index) == v.bp_idx && bp_cnt < 5) begin
                out_ready = 1'b0;
                bp_cnt++;
            end
            if (out_valid && int'(out_index) == v.mid_idx && !mid_sent) begin
                start = 1'b1;
                mid_sent = 1'b1;
            end
            if (out_valid && int'(out_index) == v.abort_idx) begin
                out_ready = 1'b1;
                abort = 1'b1;
                tick();
                abort = 1'b0;
                out_ready = 1'b0;
                chk("abort_valid", 64'(out_valid), 64'(0));
                chk("abort_busy", 64'(busy), 64'(0));
                fin = 1'b1;
            end else begin
                tick();
            end
            n++;
        end
        chk("dump_finished", 64'(fin || done_cnt != 0), 64'(1));
        start = 1'b0;
        out_ready = 1'b0;
        repeat (4) tick();

        chk("word_count", 64'(got_idx.size()), 64'(v.exp_words));
        lim = (got_idx.size() < v.exp_words) ? got_idx.size() : v.exp_words;
        for (int i = 0; i < lim; i++) begin
            chk("word_index", 64'(got_idx[i]), 64'(i + 1));
            chk("word_data", 64'(got_dat[i]), 64'(regs[i + 1]));
        end
        chk("idle_busy", 64'(busy), 64'(0));
        if (v.abort_idx >= 0) begin
            chk("abort_no_done", 64'(done_cnt), 64'(0));
            chk("abort_partial_cs", 64'(checksum), 64'(part));
        end else begin
            chk("done_once", 64'(done_cnt), 64'(1));
            chk("cs_stable", 64'(checksum), 64'(cs));
        end
        cs_chk_en = 1'b0;
    endtask

    vec_t tbl [7];

    initial begin
        logic [DW-1:0] cs4;
        int n;
        tbl[0] = '{100, -1, -1, -1, 0, 31};  // full dump, i*0x11
        tbl[1] = '{100,  3, -1, -1, 1, 31};  // backpressure on index 3
        tbl[2] = '{100, -1, 10, -1, 1,  9};  // abort at index 10 with ready high
        tbl[3] = '{100, -1, -1, -1, 1, 31};  // restart after abort
        tbl[4] = '{100, -1, -1, 12, 1, 31};  // start while busy
        tbl[5] = '{ 60, -1, -1, -1, 1, 31};  // random backpressure
        tbl[6] = '{ 30,  7, -1, 20, 1, 31};  // heavy backpressure, mixed

        rst_n = 1'b0; start = 1'b1; abort = 1'b0; out_ready = 1'b1;
        rst_n2 = 1'b0; start2 = 1'b0; abort2 = 1'b0; ready2 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fill_regs(1);
            tick();
        end
        chk("rst_addr", 64'(rd_addr), 64'(0));
        chk("rst_valid", 64'(out_valid), 64'(0));
        chk("rst_data", 64'(out_data), 64'(0));
        chk("rst_index", 64'(out_index), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_checksum", 64'(checksum), 64'(0));
        rst_n = 1'b1; rst_n2 = 1'b1; start = 1'b0; out_ready = 1'b0;
        tick();

        // start and abort together in IDLE: stays idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 64'(busy), 64'(0));
        tick();
        chk("start_abort_valid", 64'(out_valid), 64'(0));
        chk("start_abort_busy2", 64'(busy), 64'(0));

        for (int t = 0; t < 7; t++) dump(tbl[t]);

        // small instance: indices 0..3, done right after index 3 is taken
        fill_regs(1);
        cs4 = regs[0] ^ regs[1] ^ regs[2] ^ regs[3];
        got2_idx.delete();
        got2_dat.delete();
        done2_cnt = 0;
        ready2 = 1'b1;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n = 0;
        while (n < 100 && done2_cnt == 0) begin
            tick();
            n++;
        end
        repeat (3) tick();
        chk("n4_word_count", 64'(got2_idx.size()), 64'(4));
        for (int i = 0; i < 4 && i < got2_idx.size(); i++) begin
            chk("n4_index", 64'(got2_idx[i]), 64'(i));
            chk("n4_data", 64'(got2_dat[i]), 64'(regs[i]));
        end
        chk("n4_done_once", 64'(done2_cnt), 64'(1));
        chk("n4_done_after_last", 64'(done2_cyc), 64'(acc3_cyc + 1));
        chk("n4_checksum", 64'(checksum2), 64'(cs4));

        // reset in the middle of a dump
        ready2 = 1'b0;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        repeat (3) tick();
        chk("n4_mid_valid", 64'(out_valid2), 64'(1));
        rst_n2 = 1'b0;
        tick();
        chk("n4_rst_addr", 64'(rd_addr2), 64'(0));
        chk("n4_rst_valid", 64'(out_valid2), 64'(0));
        chk("n4_rst_data", 64'(out_data2), 64'(0));
        chk("n4_rst_index", 64'(out_index2), 64'(0));
        chk("n4_rst_busy", 64'(busy2), 64'(0));
        chk("n4_rst_done", 64'(done2), 64'(0));
        chk("n4_rst_checksum", 64'(checksum2), 64'(0));
        rst_n2 = 1'b1;
        tick();
        chk("n4_post_rst_busy", 64'(busy2), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
